// File: rtl/sim_sdpram_be.sv
// Single-clock simple dual-port RAM behavioural model: port A writes, port B reads.
// Provides per-byte write enables, read latency of 1 or 2, a selectable
// read-during-write policy, read-valid tracking and collision flagging.
//
// Ports:
//   clk     - single clock, all state updates on posedge
//   rst     - synchronous active-high reset of the read pipeline (not the array)
//   ena     - port A enable
//   wea     - per-byte write enables, bit i covers dina[i*BYTE_SIZE +: BYTE_SIZE]
//   addra   - write address
//   dina    - write data
//   enb     - port B read enable
//   regceb  - output register enable (READ_LATENCY=2 only)
//   addrb   - read address
//   doutb   - read data
//   rvalid  - doutb carries data from a read issued READ_LATENCY cycles earlier
//   coll    - the read presented on doutb collided with a same-cycle write
module sim_sdpram_be #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned BYTE_SIZE    = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_FIRST  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic [WIDTH/BYTE_SIZE-1:0]       wea,
  input  logic [$clog2(DEPTH)-1:0]         addra,
  input  logic [WIDTH-1:0]                 dina,
  input  logic                             enb,
  input  logic                             regceb,
  input  logic [$clog2(DEPTH)-1:0]         addrb,
  output logic [WIDTH-1:0]                 doutb,
  output logic                             rvalid,
  output logic                             coll
);

  localparam int unsigned NB = WIDTH / BYTE_SIZE;
  localparam int unsigned AW = $clog2(DEPTH);

  // Parameter legality checks at elaboration
  if (WIDTH % BYTE_SIZE != 0) begin : g_bad_width
    $error("sim_sdpram_be: WIDTH must be a multiple of BYTE_SIZE");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sim_sdpram_be: READ_LATENCY must be 1 or 2");
  end

  // Array starts at all zeros; rst never touches it
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic             wr_ok_c;
  logic             rd_ok_c;
  logic             coll_c;
  logic [WIDTH-1:0] rd_word_c;
  logic [WIDTH-1:0] fwd_word_c;

  logic [WIDTH-1:0] d1;
  logic             c1;
  logic             v1;

  // Address range qualification; only needed when DEPTH leaves holes in the address space
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign wr_ok_c = 1'b1;
    assign rd_ok_c = 1'b1;
  end else begin : g_npow2
    assign wr_ok_c = (addra < AW'(DEPTH));
    assign rd_ok_c = (addrb < AW'(DEPTH));
  end

  // Byte-masked write port
  always_ff @(posedge clk) begin
    if (ena && wr_ok_c) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wea[i]) begin
          mem[addra][i*BYTE_SIZE +: BYTE_SIZE] <= dina[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  // Read word with optional write-first forwarding of the enabled lanes
  always_comb begin
    rd_word_c  = rd_ok_c ? mem[addrb] : '0;
    coll_c     = ena && (|wea) && (addra == addrb);
    fwd_word_c = rd_word_c;
    if ((WRITE_FIRST != 0) && coll_c && wr_ok_c && rd_ok_c) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wea[i]) begin
          fwd_word_c[i*BYTE_SIZE +: BYTE_SIZE] = dina[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  // Stage 1: data and collision flag hold while enb is low; valid tracks enb
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      c1 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v1 <= enb;
      if (enb) begin
        d1 <= fwd_word_c;
        c1 <= coll_c;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] d2;
    logic             c2;
    logic             v2;

    // Stage 2: whole stage advances together under regceb
    always_ff @(posedge clk) begin
      if (rst) begin
        d2 <= '0;
        c2 <= 1'b0;
        v2 <= 1'b0;
      end else if (regceb) begin
        d2 <= d1;
        c2 <= c1;
        v2 <= v1;
      end
    end

    assign doutb  = d2;
    assign coll   = c2;
    assign rvalid = v2;
  end else begin : g_lat1
    assign doutb  = d1;
    assign coll   = c1;
    assign rvalid = v1;
  end

endmodule

// File: tb/tb_sim_sdpram_be.sv
// Directed testbench for sim_sdpram_be. Three instances share one stimulus stream:
//   u_a: READ_LATENCY=1, read-first,  DEPTH=256
//   u_b: READ_LATENCY=1, write-first, DEPTH=256
//   u_c: READ_LATENCY=2, read-first,  DEPTH=200 (exercises out-of-range addresses)
module tb_sim_sdpram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [7:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic        regceb;
  logic [7:0]  addrb;

  logic [31:0] dout_a, dout_b, dout_c;
  logic        rv_a, rv_b, rv_c;
  logic        co_a, co_b, co_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sim_sdpram_be #(.WIDTH(32), .DEPTH(256), .BYTE_SIZE(8), .READ_LATENCY(1), .WRITE_FIRST(0)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout_a), .rvalid(rv_a), .coll(co_a));

  sim_sdpram_be #(.WIDTH(32), .DEPTH(256), .BYTE_SIZE(8), .READ_LATENCY(1), .WRITE_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout_b), .rvalid(rv_b), .coll(co_b));

  sim_sdpram_be #(.WIDTH(32), .DEPTH(200), .BYTE_SIZE(8), .READ_LATENCY(2), .WRITE_FIRST(0)) u_c (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout_c), .rvalid(rv_c), .coll(co_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
    ena   = 1'b1;
    addra = a;
    dina  = d;
    wea   = we;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; wea = 4'h0; addra = 8'd0; dina = 32'h0;
    enb = 1'b0; regceb = 1'b1; addrb = 8'd0;

    // Reset state
    tick();
    rst = 1'b0;
    chk("rst_dout_a", dout_a, 32'h0);
    chk("rst_rv_a", 32'(rv_a), 32'h0);
    chk("rst_co_a", 32'(co_a), 32'h0);
    chk("rst_rv_b", 32'(rv_b), 32'h0);
    chk("rst_dout_c", dout_c, 32'h0);
    chk("rst_rv_c", 32'(rv_c), 32'h0);
    chk("rst_co_c", 32'(co_c), 32'h0);

    // Read of untouched address 5
    enb = 1'b1; addrb = 8'd5;
    tick();
    enb = 1'b0;
    chk("rd5_dout_a", dout_a, 32'h0);
    chk("rd5_rv_a", 32'(rv_a), 32'h1);
    chk("rd5_co_a", 32'(co_a), 32'h0);
    chk("rd5_rv_c_early", 32'(rv_c), 32'h0);
    tick();
    chk("rd5_rv_a_drop", 32'(rv_a), 32'h0);
    chk("rd5_rv_c", 32'(rv_c), 32'h1);
    chk("rd5_dout_c", dout_c, 32'h0);

    // Byte-lane writes merge into addr 3
    set_wr(8'd3, 32'hAABBCCDD, 4'b1111);
    tick();
    set_wr(8'd3, 32'h11223344, 4'b0101);
    tick();
    ena = 1'b0;
    enb = 1'b1; addrb = 8'd3;
    tick();
    enb = 1'b0;
    chk("be_dout_a", dout_a, 32'hAA22CC44);
    chk("be_rv_a", 32'(rv_a), 32'h1);
    chk("be_dout_b", dout_b, 32'hAA22CC44);
    tick();
    chk("be_dout_c", dout_c, 32'hAA22CC44);
    chk("be_rv_c", 32'(rv_c), 32'h1);

    // Same-cycle write and read of addr 7
    set_wr(8'd7, 32'hDEADBEEF, 4'b1111);
    enb = 1'b1; addrb = 8'd7;
    tick();
    ena = 1'b0;
    chk("coll_dout_rf", dout_a, 32'h0);
    chk("coll_flag_rf", 32'(co_a), 32'h1);
    chk("coll_dout_wf", dout_b, 32'hDEADBEEF);
    chk("coll_flag_wf", 32'(co_b), 32'h1);
    tick();
    enb = 1'b0;
    chk("after_coll_dout_a", dout_a, 32'hDEADBEEF);
    chk("after_coll_co_a", 32'(co_a), 32'h0);
    chk("after_coll_dout_b", dout_b, 32'hDEADBEEF);
    chk("after_coll_co_b", 32'(co_b), 32'h0);
    chk("coll_dout_c", dout_c, 32'h0);
    chk("coll_flag_c", 32'(co_c), 32'h1);
    tick();
    chk("after_coll_dout_c", dout_c, 32'hDEADBEEF);
    chk("after_coll_co_c", 32'(co_c), 32'h0);

    // Two-stage latency and regceb hold
    set_wr(8'd1, 32'h1, 4'b1111);
    tick();
    set_wr(8'd2, 32'h2, 4'b1111);
    tick();
    ena = 1'b0;
    enb = 1'b1; addrb = 8'd1;
    tick();
    addrb = 8'd2;
    chk("l2_dout_a_1", dout_a, 32'h1);
    tick();
    enb = 1'b0;
    chk("l2_dout_c_1", dout_c, 32'h1);
    chk("l2_rv_c_1", 32'(rv_c), 32'h1);
    chk("l2_dout_a_2", dout_a, 32'h2);
    tick();
    chk("l2_dout_c_2", dout_c, 32'h2);
    chk("l2_rv_c_2", 32'(rv_c), 32'h1);
    regceb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l2_hold_dout_c", dout_c, 32'h2);
      chk("l2_hold_rv_c", 32'(rv_c), 32'h1);
    end
    regceb = 1'b1;
    tick();
    chk("l2_release_rv_c", 32'(rv_c), 32'h0);
    chk("l2_release_dout_c", dout_c, 32'h2);

    // Hold while enb is low; ena with wea=0 must not write
    set_wr(8'd9, 32'h55, 4'b1111);
    tick();
    ena = 1'b0;
    enb = 1'b1; addrb = 8'd9;
    tick();
    enb = 1'b0;
    chk("hold_dout_a", dout_a, 32'h55);
    chk("hold_rv_a", 32'(rv_a), 32'h1);
    set_wr(8'd9, 32'hFFFFFFFF, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_idle_dout_a", dout_a, 32'h55);
      chk("hold_idle_rv_a", 32'(rv_a), 32'h0);
      chk("hold_idle_co_a", 32'(co_a), 32'h0);
    end
    ena = 1'b0;
    enb = 1'b1; addrb = 8'd9;
    tick();
    enb = 1'b0;
    chk("noop_wr_dout_a", dout_a, 32'h55);

    // Address 250 is out of range for the 200-deep instance only
    set_wr(8'd250, 32'hCAFEF00D, 4'b1111);
    tick();
    ena = 1'b0;
    enb = 1'b1; addrb = 8'd250;
    tick();
    enb = 1'b0;
    chk("oor_dout_a", dout_a, 32'hCAFEF00D);
    tick();
    chk("oor_dout_c", dout_c, 32'h0);
    chk("oor_rv_c", 32'(rv_c), 32'h1);

    // Reset while a two-stage read is in flight; write during reset still commits
    enb = 1'b1; addrb = 8'd9;
    tick();
    enb = 1'b0;
    rst = 1'b1;
    set_wr(8'd11, 32'h12345678, 4'b1111);
    tick();
    rst = 1'b0;
    ena = 1'b0;
    chk("midrst_rv_c_0", 32'(rv_c), 32'h0);
    chk("midrst_dout_c_0", dout_c, 32'h0);
    chk("midrst_rv_a", 32'(rv_a), 32'h0);
    chk("midrst_dout_a", dout_a, 32'h0);
    tick();
    chk("midrst_rv_c_1", 32'(rv_c), 32'h0);
    chk("midrst_dout_c_1", dout_c, 32'h0);
    tick();
    chk("midrst_rv_c_2", 32'(rv_c), 32'h0);
    enb = 1'b1; addrb = 8'd3;
    tick();
    enb = 1'b0;
    tick();
    chk("post_rst_dout_c", dout_c, 32'hAA22CC44);
    chk("post_rst_rv_c", 32'(rv_c), 32'h1);
    enb = 1'b1; addrb = 8'd11;
    tick();
    enb = 1'b0;
    chk("rst_wr_dout_a", dout_a, 32'h12345678);
    tick();
    chk("rst_wr_dout_c", dout_c, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
